// File: rtl/chip8_fb_pkg.sv
// ---------------------------------------------------------------------------
// chip8_fb_pkg
// Shared definitions for the CHIP-8 sprite drawer: framebuffer geometry,
// sprite width and the drawer FSM state encoding.
// ---------------------------------------------------------------------------
package chip8_fb_pkg;

    localparam int FB_W     = 64;
    localparam int FB_H     = 32;
    localparam int SPRITE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_XOR   = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/chip8_row_mask.sv
// ---------------------------------------------------------------------------
// chip8_row_mask
// Combinational expansion of one sprite byte into a full framebuffer-row
// mask. Sprite bit 7-k lands on column (x0 + k) mod FB_W_P, so a sprite that
// runs off the right edge reappears at column 0.
//
// Ports
//   sprite_byte_i : sprite row byte, MSB is the leftmost pixel
//   x0_i          : starting column, already reduced mod FB_W_P
//   mask_o        : FB_W_P-bit row mask, bit c = pixel at column c
// ---------------------------------------------------------------------------
module chip8_row_mask
    import chip8_fb_pkg::*;
#(
    parameter int FB_W_P = 64
) (
    input  logic [SPRITE_W-1:0]       sprite_byte_i,
    input  logic [$clog2(FB_W_P)-1:0] x0_i,
    output logic [FB_W_P-1:0]         mask_o
);

    // Scatter the eight sprite bits onto their wrapped column positions.
    always_comb begin
        mask_o = '0;
        for (int k = 0; k < SPRITE_W; k++) begin
            mask_o[(int'(x0_i) + k) % FB_W_P] = sprite_byte_i[SPRITE_W-1-k];
        end
    end

endmodule

// File: rtl/chip8_sprite_drawer.sv
// ---------------------------------------------------------------------------
// chip8_sprite_drawer
// Executes the CHIP-8 DXYN (XOR sprite draw) and CLS (clear screen)
// instructions against an internal framebuffer. One sprite row is handled
// per FETCH/XOR cycle pair; a clear takes a single cycle.
//
// Ports
//   clk50       : system clock
//   reset       : asynchronous, active-high reset
//   draw_start  : one-cycle DXYN request (accepted only when idle)
//   clear_start : one-cycle CLS request, wins over draw_start
//   x, y, n     : Vx, Vy and sprite height, sampled on accept
//   i_addr      : sprite base address I, sampled on accept
//   mem_rd      : memory read strobe (high during FETCH only)
//   mem_addr    : memory read address, holds outside FETCH
//   mem_rdata   : read data, valid one cycle after mem_rd
//   busy        : high whenever the FSM is not idle
//   done        : one-cycle completion pulse
//   collision   : VF result of the last command
//   framebuffer : bit (row*FB_W + col) is pixel (col,row), 1 = on
// ---------------------------------------------------------------------------
module chip8_sprite_drawer #(
    parameter int FB_W = chip8_fb_pkg::FB_W,
    parameter int FB_H = chip8_fb_pkg::FB_H
) (
    input  logic                 clk50,
    input  logic                 reset,
    input  logic                 draw_start,
    input  logic                 clear_start,
    input  logic [7:0]           x,
    input  logic [7:0]           y,
    input  logic [3:0]           n,
    input  logic [11:0]          i_addr,
    output logic                 mem_rd,
    output logic [11:0]          mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 collision,
    output logic [FB_W*FB_H-1:0] framebuffer
);

    import chip8_fb_pkg::*;

    localparam int XW = $clog2(FB_W);
    localparam int YW = $clog2(FB_H);
    localparam int SW = ((YW > 4) ? YW : 4) + 1;
    localparam int BW = $clog2(FB_W * FB_H);

    state_e              state_q, state_d;
    logic [XW-1:0]       x0_q;
    logic [YW-1:0]       y0_q;
    logic [3:0]          n_q;
    logic [3:0]          r_q;
    logic [11:0]         iaddr_q;
    logic                collision_q;
    logic                mem_rd_q;
    logic [11:0]         mem_addr_q;
    logic                busy_q;
    logic                done_q;
    logic [FB_W*FB_H-1:0] fb_q;

    logic                accept_s;
    logic [11:0]         addr_next_s;
    logic [SW-1:0]       row_sum_s;
    logic [YW-1:0]       row_idx_s;
    logic [BW-1:0]       row_base_s;
    logic [FB_W-1:0]     fb_row_s;
    logic [FB_W-1:0]     mask_s;
    logic                hit_s;

    assign accept_s = (state_q == ST_IDLE) && (clear_start || draw_start);

    // Next-state logic; clear wins over draw, requests outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                end else if (draw_start) begin
                    state_d = (n == 4'd0) ? ST_DONE : ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: state_d = ST_XOR;
            ST_XOR:   state_d = (r_q == (n_q - 4'd1)) ? ST_DONE : ST_FETCH;
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Address of the row about to be fetched: row 0 straight from the
    // inputs on accept, otherwise the row after the one just drawn.
    always_comb begin
        if (state_q == ST_IDLE) begin
            addr_next_s = i_addr;
        end else begin
            addr_next_s = iaddr_q + {8'd0, r_q + 4'd1};
        end
    end

    // Target framebuffer row for the current sprite row, wrapped vertically.
    always_comb begin
        row_sum_s  = SW'(y0_q) + SW'(r_q);
        row_idx_s  = YW'(row_sum_s % SW'(FB_H));
        row_base_s = BW'(int'(row_idx_s) * FB_W);
        fb_row_s   = fb_q[row_base_s +: FB_W];
        hit_s      = |(fb_row_s & mask_s);
    end

    chip8_row_mask #(
        .FB_W_P (FB_W)
    ) u_row_mask (
        .sprite_byte_i (mem_rdata),
        .x0_i          (x0_q),
        .mask_o        (mask_s)
    );

    // Control registers: state, command operands, row counter and
    // registered status outputs decoded from the next state.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            n_q         <= 4'd0;
            r_q         <= 4'd0;
            iaddr_q     <= 12'd0;
            collision_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= 12'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
            mem_rd_q <= (state_d == ST_FETCH);
            if (state_d == ST_FETCH) begin
                mem_addr_q <= addr_next_s;
            end
            if (accept_s) begin
                x0_q        <= XW'(x % 8'(FB_W));
                y0_q        <= YW'(y % 8'(FB_H));
                n_q         <= n;
                iaddr_q     <= i_addr;
                r_q         <= 4'd0;
                collision_q <= 1'b0;
            end else if (state_q == ST_XOR) begin
                if (hit_s) begin
                    collision_q <= 1'b1;
                end
                if (state_d == ST_FETCH) begin
                    r_q <= r_q + 4'd1;
                end
            end
        end
    end

    // Framebuffer store: one whole row XORed at the end of XOR, all bits
    // cleared at the end of CLEAR, untouched otherwise.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            fb_q <= '0;
        end else if (state_q == ST_XOR) begin
            fb_q[row_base_s +: FB_W] <= fb_row_s ^ mask_s;
        end else if (state_q == ST_CLEAR) begin
            fb_q <= '0;
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign collision   = collision_q;
    assign framebuffer = fb_q;

endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// ---------------------------------------------------------------------------
// tb_chip8_sprite_drawer
// Randomized self-checking bench. A pixel-level reference model (flat bit
// array, plain modulo arithmetic) predicts framebuffer, collision, latency
// and read addresses for every command.
// ---------------------------------------------------------------------------
module tb_chip8_sprite_drawer;

    logic          clk50 = 1'b0;
    logic          reset;
    logic          draw_start;
    logic          clear_start;
    logic [7:0]    x;
    logic [7:0]    y;
    logic [3:0]    n;
    logic [11:0]   i_addr;
    logic          mem_rd;
    logic [11:0]   mem_addr;
    logic [7:0]    mem_rdata;
    logic          busy;
    logic          done;
    logic          collision;
    logic [2047:0] framebuffer;

    logic [7:0]    mem [0:4095];
    logic [2047:0] fb_m;
    int            n_cmp = 0;
    int            n_mis = 0;

    chip8_sprite_drawer dut (
        .clk50       (clk50),
        .reset       (reset),
        .draw_start  (draw_start),
        .clear_start (clear_start),
        .x           (x),
        .y           (y),
        .n           (n),
        .i_addr      (i_addr),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .done        (done),
        .collision   (collision),
        .framebuffer (framebuffer)
    );

    always #10 clk50 = ~clk50;

    // Memory: data one cycle after the strobe, garbage otherwise.
    always @(posedge clk50) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        else        mem_rdata <= 8'($urandom);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_fb();
        for (int r = 0; r < 32; r++) begin
            check_val($sformatf("fb_row%0d", r), framebuffer[r*64 +: 64], fb_m[r*64 +: 64]);
        end
    endtask

    // Reference: apply a command to the pixel array, return expected VF.
    task automatic model_cmd(input bit is_clear, input logic [7:0] xx, input logic [7:0] yy,
                             input logic [3:0] nn, input logic [11:0] ia, output bit coll);
        coll = 1'b0;
        if (is_clear) begin
            fb_m = '0;
        end else begin
            for (int rr = 0; rr < int'(nn); rr++) begin
                logic [7:0] b;
                b = mem[(int'(ia) + rr) % 4096];
                for (int k = 0; k < 8; k++) begin
                    if (b[7-k]) begin
                        int idx;
                        idx = ((int'(yy) % 32 + rr) % 32) * 64 + (int'(xx) % 64 + k) % 64;
                        if (fb_m[idx]) coll = 1'b1;
                        fb_m[idx] = ~fb_m[idx];
                    end
                end
            end
        end
    endtask

    // Issue one command at a negedge and follow it to completion. poke_cyc
    // (>0) raises a stray request during that busy cycle, which must be ignored.
    task automatic run_cmd(input bit is_clear, input bit both, input logic [7:0] xx,
                           input logic [7:0] yy, input logic [3:0] nn,
                           input logic [11:0] ia, input int poke_cyc);
        int cyc, lat, rds, exp_lat;
        bit exp_coll;
        exp_lat = is_clear ? 2 : ((nn == 4'd0) ? 1 : 2 * int'(nn) + 1);
        model_cmd(is_clear, xx, yy, nn, ia, exp_coll);
        clear_start = is_clear;
        draw_start  = !is_clear || both;
        x = xx; y = yy; n = nn; i_addr = ia;
        @(negedge clk50);
        cyc = 1; lat = 0; rds = 0;
        while (lat == 0 && cyc <= exp_lat + 4) begin
            draw_start  = (cyc == poke_cyc);
            clear_start = (cyc == poke_cyc) && ($urandom_range(1) == 1);
            if (cyc == poke_cyc) begin
                x = 8'($urandom); n = 4'($urandom); i_addr = 12'($urandom);
            end
            if (mem_rd) begin
                check_val("mem_addr", 64'(mem_addr), 64'((int'(ia) + rds) % 4096));
                rds++;
            end
            check_val("busy_run", 64'(busy), 64'd1);
            if (done) lat = cyc;
            else begin
                @(negedge clk50);
                cyc++;
            end
        end
        check_val("latency", 64'(lat), 64'(exp_lat));
        draw_start = 1'b0; clear_start = 1'b0;
        @(negedge clk50);
        check_val("busy_after", 64'(busy), 64'd0);
        check_val("done_once", 64'(done), 64'd0);
        check_val("mem_rd_after", 64'(mem_rd), 64'd0);
        check_val("reads", 64'(rds), is_clear ? 64'd0 : 64'(nn));
        check_val("collision", 64'(collision), 64'(exp_coll));
        check_fb();
    endtask

    initial begin
        int  dones;
        bit  c;
        logic [7:0]  rx, ry;
        logic [3:0]  rn;
        logic [11:0] ra;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        fb_m = '0;
        reset = 1'b1; draw_start = 1'b0; clear_start = 1'b0;
        x = 8'd0; y = 8'd0; n = 4'd0; i_addr = 12'd0;
        repeat (3) @(negedge clk50);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_mem_rd", 64'(mem_rd), 64'd0);
        check_val("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_val("rst_collision", 64'(collision), 64'd0);
        check_fb();
        reset = 1'b0;
        @(negedge clk50);

        // Clear from reset.
        run_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'd0, 0);

        // Single-row draw, then the same draw again erases it with VF=1.
        mem[12'h050] = 8'hF0;
        run_cmd(1'b0, 1'b0, 8'd0, 8'd0, 4'd1, 12'h050, 0);
        check_val("req40_row0", framebuffer[63:0], 64'h0000_0000_0000_000F);
        check_val("req40_coll", 64'(collision), 64'd0);
        run_cmd(1'b0, 1'b0, 8'd0, 8'd0, 4'd1, 12'h050, 0);
        check_val("req41_row0", framebuffer[63:0], 64'd0);
        check_val("req41_coll", 64'(collision), 64'd1);

        // Corner wrap in both directions, x given directly and as x+64.
        mem[12'h200] = 8'hFF; mem[12'h201] = 8'h81;
        for (int v = 0; v < 2; v++) begin
            run_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'd0, 0);
            run_cmd(1'b0, 1'b0, (v == 0) ? 8'd62 : 8'd126, 8'd31, 4'd2, 12'h200, 0);
            check_val("wrap_row31", framebuffer[31*64 +: 64], 64'hC000_0000_0000_003F);
            check_val("wrap_row0", framebuffer[63:0], 64'h4000_0000_0000_0020);
        end

        // Zero-height draw on a non-empty screen: nothing read, nothing changed.
        run_cmd(1'b0, 1'b0, 8'd17, 8'd9, 4'd0, 12'h3A0, 0);

        // Randomized commands, with stray requests while busy.
        for (int t = 0; t < 30; t++) begin
            rx = 8'($urandom); ry = 8'($urandom); rn = 4'($urandom);
            ra = (t % 5 == 0) ? 12'(12'hFF8 + 12'($urandom_range(7))) : 12'($urandom);
            if ($urandom_range(7) == 0)
                run_cmd(1'b1, 1'b0, rx, ry, rn, ra, int'($urandom_range(2)));
            else
                run_cmd(1'b0, 1'b0, rx, ry, rn, ra, int'($urandom_range(2 * int'(rn) + 1)));
        end

        // Both requests together: clear only, plus a stray request while busy.
        run_cmd(1'b0, 1'b0, 8'd5, 8'd5, 4'd3, 12'h123, 0);
        run_cmd(1'b1, 1'b1, 8'd5, 8'd5, 4'd3, 12'h123, 1);

        // Reset during a FETCH of an n=15 draw aborts it silently.
        draw_start = 1'b1; x = 8'd20; y = 8'd3; n = 4'd15; i_addr = 12'h400;
        @(negedge clk50);
        draw_start = 1'b0;
        @(negedge clk50);
        @(negedge clk50);
        check_val("abort_in_fetch", 64'(mem_rd), 64'd1);
        reset = 1'b1;
        fb_m = '0;
        #1;
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_mem_rd", 64'(mem_rd), 64'd0);
        check_val("abort_mem_addr", 64'(mem_addr), 64'd0);
        check_val("abort_coll", 64'(collision), 64'd0);
        check_fb();
        @(negedge clk50);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk50);
            if (done || busy) dones++;
        end
        check_val("abort_no_done", 64'(dones), 64'd0);
        check_fb();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/chip8_sprite_drawer.md
CHIP8_SPRITE_DRAWER -- requirements
Module: chip8_sprite_drawer

Interface
REQ-001 SHALL have parameter FB_W, default 64, meaning framebuffer width in pixels.
REQ-002 SHALL have parameter FB_H, default 32, meaning framebuffer height in pixels.
REQ-003 SHALL have port clk50  input  1  system clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port draw_start  input  1  one-cycle request to execute DXYN.
REQ-006 SHALL have port clear_start  input  1  one-cycle request to execute CLS.
REQ-007 SHALL have port x  input  8  Vx value, sampled on accept.
REQ-008 SHALL have port y  input  8  Vy value, sampled on accept.
REQ-009 SHALL have port n  input  4  sprite height in rows, sampled on accept.
REQ-010 SHALL have port i_addr  input  12  sprite base address (I), sampled on accept.
REQ-011 SHALL have port mem_rd  output  1  memory read strobe.
REQ-012 SHALL have port mem_addr  output  12  memory read address.
REQ-013 SHALL have port mem_rdata  input  8  read data, valid exactly 1 cycle after mem_rd.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port collision  output  1  VF result of last command.
REQ-017 SHALL have port framebuffer  output  FB_W*FB_H (2048)  pixel store; bit (row*64 + col) is pixel (col,row), 1 = on.

Function
REQ-018 SHALL implement states IDLE, FETCH, XOR, CLEAR, DONE.
REQ-019 SHALL accept a command only in IDLE; draw_start/clear_start in any other state SHALL be ignored.
REQ-020 SHALL give clear_start priority over draw_start when both are high in IDLE.
REQ-021 On accept, SHALL register x0 = x mod 64, y0 = y mod 32, n, i_addr, set row counter r = 0, and clear collision.
REQ-022 Draw accept with n = 0 SHALL go directly to DONE; no memory read, no framebuffer change, collision = 0.
REQ-023 Draw accept with n > 0 SHALL go to FETCH.
REQ-024 FETCH (one cycle) SHALL drive mem_rd = 1, mem_addr = (i_addr + r) mod 4096, then go to XOR.
REQ-025 XOR (one cycle) SHALL sample mem_rdata; bit 7-k is the pixel at column (x0+k) mod 64, row (y0+r) mod 32, k = 0..7.
REQ-026 At the end of XOR SHALL XOR all 8 pixels into the framebuffer in that single edge.
REQ-027 SHALL set collision if any sprite bit 1 hits a framebuffer bit already 1; collision is sticky until the next accept.
REQ-028 After XOR, if r = n-1 SHALL go to DONE, else r++ and go to FETCH.
REQ-029 Clear accept SHALL go to CLEAR; at the end of CLEAR all 2048 bits SHALL be 0; then go to DONE; collision SHALL remain 0.
REQ-030 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-031 Latency: draw accepted at cycle 0 SHALL pulse done at cycle 2n+1 (n>0), cycle 1 (n=0); clear SHALL pulse done at cycle 2.
REQ-032 Horizontal wrap: pixels past column 63 SHALL wrap to column 0; vertical wrap: rows past 31 SHALL wrap to row 0.
REQ-033 mem_rd SHALL be 0 and mem_addr SHALL hold its last value outside FETCH.
REQ-034 framebuffer SHALL change only at the end of XOR or CLEAR; it SHALL be stable in all other cycles.

Reset
REQ-035 reset SHALL force state IDLE, framebuffer all 0, r = 0, collision 0, done 0, busy 0, mem_rd 0, mem_addr 0.
REQ-036 reset asserted mid-command SHALL abort it with no done pulse; framebuffer SHALL read 0 after reset.

Structure
REQ-037 The state enum, FB_W, FB_H and SPRITE_W = 8 SHALL live in a shared package chip8_fb_pkg.
REQ-038 One sub-module SHALL exist: chip8_row_mask, combinational, mapping (byte, x0) to a 64-bit wrapped row mask; the XOR and collision logic SHALL use this mask.

Verification
REQ-039 Reset then clear_start -> busy cycles 1-2, done at cycle 2, framebuffer = 0, collision = 0.
REQ-040 Draw x=0, y=0, n=1, i_addr=0x050, mem[0x050]=0xF0 -> mem_addr 0x050 at cycle 1, done at cycle 3, bits 0..3 = 1, collision = 0.
REQ-041 Repeat REQ-040 draw -> bits 0..3 = 0, collision = 1.
REQ-042 Draw x=62 (also x=126), y=31, n=2, bytes 0xFF,0x81 -> row 31 columns 62,63,0..5 on; row 0 columns 62 and 5 on; done at cycle 5.
REQ-043 Draw n=0 -> done at cycle 1, mem_rd never high, framebuffer unchanged.
REQ-044 draw_start and clear_start together in IDLE, then draw_start while busy, then reset asserted during a FETCH of an n=15 draw -> clear executes only, busy-time request ignored, no done, framebuffer 0, state IDLE.
